// File: rtl/cpu_params_pkg.sv
// Shared CPU configuration constants used as defaults by the pipeline units.
package cpu_params_pkg;

    localparam int BHT_DEPTH_DEFAULT = 64;

    // Power-up / reset state of every branch history counter: weakly not taken.
    localparam logic [1:0] BHT_INIT = 2'b01;

endpackage

// File: rtl/cpu_structs_pkg.sv
// Shared CPU enumerations: branch unit operation and operand-select encodings.
package cpu_structs_pkg;

    typedef enum logic [1:0] {
        B_ADD  = 2'd0,
        B_JAL  = 2'd1,
        B_JALR = 2'd2,
        B_MRET = 2'd3
    } BR_OP_TYPE;

    // Encoding 3 is unused and selects a zero operand.
    typedef enum logic [1:0] {
        BS_RS1 = 2'd0,
        BS_IMM = 2'd1,
        BS_PC  = 2'd2
    } BR_SEL_TYPE;

endpackage

// File: rtl/br_pred_fu_if.sv
// Execute-side handshake and result bus of the branch unit, plus the
// fetch-side branch history lookup port.
interface br_pred_fu_if #(
    parameter int RSZ   = 32,
    parameter int PC_SZ = 32
);
    import cpu_structs_pkg::*;

    logic              flush_in;
    logic              valid_in;
    logic              ready_out;
    BR_OP_TYPE         op_in;
    BR_SEL_TYPE        sel_x_in;
    BR_SEL_TYPE        sel_y_in;
    logic [RSZ-1:0]    rs1_in;
    logic [RSZ-1:0]    rs2_in;
    logic [RSZ-1:0]    imm_in;
    logic [PC_SZ-1:0]  pc_in;
    logic [2:0]        funct3_in;
    logic              ci_in;
    logic [PC_SZ-1:0]  mepc_in;
    logic              pred_taken_in;
    logic [PC_SZ-1:0]  pred_pc_in;
    logic [PC_SZ-1:0]  lookup_pc_in;
    logic              lookup_taken_out;
    logic              valid_out;
    logic              ready_in;
    logic              taken_out;
    logic [PC_SZ-1:0]  br_pc_out;
    logic [PC_SZ-1:0]  no_br_pc_out;
    logic              mis_out;
    logic              mispredict_out;
    logic [31:0]       br_cnt_out;
    logic [31:0]       mp_cnt_out;

    modport master (
        output flush_in, valid_in, op_in, sel_x_in, sel_y_in, rs1_in, rs2_in,
               imm_in, pc_in, funct3_in, ci_in, mepc_in, pred_taken_in,
               pred_pc_in, lookup_pc_in, ready_in,
        input  ready_out, lookup_taken_out, valid_out, taken_out, br_pc_out,
               no_br_pc_out, mis_out, mispredict_out, br_cnt_out, mp_cnt_out
    );

    modport slave (
        input  flush_in, valid_in, op_in, sel_x_in, sel_y_in, rs1_in, rs2_in,
               imm_in, pc_in, funct3_in, ci_in, mepc_in, pred_taken_in,
               pred_pc_in, lookup_pc_in, ready_in,
        output ready_out, lookup_taken_out, valid_out, taken_out, br_pc_out,
               no_br_pc_out, mis_out, mispredict_out, br_cnt_out, mp_cnt_out
    );

endinterface

// File: rtl/br_bht.sv
// Branch history table: DEPTH two-bit saturating counters with one
// combinational read port and one update port.
module br_bht
    import cpu_params_pkg::*;
#(
    parameter int DEPTH = BHT_DEPTH_DEFAULT
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     rd_taken,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic                     wr_taken
);

    logic [1:0] cnt [DEPTH];

    // NOTE: every counter needs a defined reset value, so this table is built
    // from flops rather than a RAM macro; RAMs cannot be cleared by a reset.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= BHT_INIT;
            end
        end else if (wr_en) begin
            if (wr_taken && cnt[wr_idx] != 2'b11) begin
                cnt[wr_idx] <= cnt[wr_idx] + 2'b01;
            end else if (!wr_taken && cnt[wr_idx] != 2'b00) begin
                cnt[wr_idx] <= cnt[wr_idx] - 2'b01;
            end
        end
    end

    // Reads see the stored value, so a same-cycle update is not forwarded.
    assign rd_taken = cnt[rd_idx][1];

endmodule

// File: rtl/br_pred_fu.sv
// Branch resolution unit: resolves direction and target, flags mispredicts,
// trains the branch history table and keeps branch/mispredict statistics.
module br_pred_fu
    import cpu_structs_pkg::*;
    import cpu_params_pkg::*;
#(
    parameter int RSZ       = 32,
    parameter int PC_SZ     = 32,
    parameter int BHT_DEPTH = BHT_DEPTH_DEFAULT,
    parameter int EXT_C     = 0
) (
    input  logic         clk_in,
    input  logic         reset_in,
    br_pred_fu_if.slave  bus
);

    localparam int AW    = (RSZ > PC_SZ) ? RSZ : PC_SZ;
    localparam int IW    = $clog2(BHT_DEPTH);
    localparam int SHIFT = (EXT_C != 0) ? 1 : 2;

    logic [AW-1:0]    x_val;
    logic [AW-1:0]    y_val;
    logic [PC_SZ-1:0] addxy;
    logic [PC_SZ-1:0] no_br_pc;
    logic [PC_SZ-1:0] br_pc;
    logic             cond;
    logic             taken;
    logic             mis;
    logic             mispredict;
    logic             ready;
    logic             accept;
    logic [IW-1:0]    lookup_idx;
    logic [IW-1:0]    upd_idx;
    logic             lookup_taken;

    logic             valid_q;
    logic             taken_q;
    logic [PC_SZ-1:0] br_pc_q;
    logic [PC_SZ-1:0] no_br_pc_q;
    logic             mis_q;
    logic             mispredict_q;
    logic [31:0]      br_cnt_q;
    logic [31:0]      mp_cnt_q;

    // NOTE: each signal gets a default before the case statements; a path
    // that leaves a combinational output unassigned would infer a latch.
    always_comb begin
        x_val = '0;
        y_val = '0;
        cond  = 1'b0;
        taken = 1'b1;
        br_pc = '0;

        case (bus.sel_x_in)
            BS_RS1:  x_val = AW'(bus.rs1_in);
            BS_IMM:  x_val = AW'(bus.imm_in);
            BS_PC:   x_val = AW'(bus.pc_in);
            default: x_val = '0;
        endcase

        case (bus.sel_y_in)
            BS_RS1:  y_val = AW'(bus.rs1_in);
            BS_IMM:  y_val = AW'(bus.imm_in);
            BS_PC:   y_val = AW'(bus.pc_in);
            default: y_val = '0;
        endcase

        addxy    = PC_SZ'(x_val + y_val);
        no_br_pc = bus.pc_in + (bus.ci_in ? PC_SZ'(2) : PC_SZ'(4));

        case (bus.funct3_in)
            3'd0:    cond = (bus.rs1_in == bus.rs2_in);
            3'd1:    cond = (bus.rs1_in != bus.rs2_in);
            3'd4:    cond = ($signed(bus.rs1_in) <  $signed(bus.rs2_in));
            3'd5:    cond = ($signed(bus.rs1_in) >= $signed(bus.rs2_in));
            3'd6:    cond = (bus.rs1_in <  bus.rs2_in);
            3'd7:    cond = (bus.rs1_in >= bus.rs2_in);
            default: cond = 1'b0;
        endcase

        br_pc = addxy;
        case (bus.op_in)
            B_ADD: begin
                taken = cond;
                br_pc = cond ? addxy : no_br_pc;
            end
            B_JALR:  br_pc = {addxy[PC_SZ-1:1], 1'b0};
            B_MRET:  br_pc = bus.mepc_in;
            default: br_pc = addxy;
        endcase
    end

    // With compressed instructions any halfword-aligned target is legal.
    assign mis        = (EXT_C != 0) ? 1'b0 : (br_pc[1:0] != 2'b00);
    assign mispredict = (taken != bus.pred_taken_in) |
                        (taken & (br_pc != bus.pred_pc_in));

    assign ready  = !valid_q || bus.ready_in;
    assign accept = bus.valid_in && ready && !bus.flush_in;

    assign lookup_idx = IW'(bus.lookup_pc_in >> SHIFT);
    assign upd_idx    = IW'(bus.pc_in >> SHIFT);

    br_bht #(.DEPTH(BHT_DEPTH)) u_bht (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .rd_idx   (lookup_idx),
        .rd_taken (lookup_taken),
        .wr_en    (accept && bus.op_in == B_ADD),
        .wr_idx   (upd_idx),
        .wr_taken (taken)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before the clock edge.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            br_pc_q      <= '0;
            no_br_pc_q   <= '0;
            mis_q        <= 1'b0;
            mispredict_q <= 1'b0;
        end else if (bus.flush_in) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q      <= 1'b1;
            taken_q      <= taken;
            br_pc_q      <= br_pc;
            no_br_pc_q   <= no_br_pc;
            mis_q        <= mis;
            mispredict_q <= mispredict;
        end else if (bus.ready_in) begin
            valid_q <= 1'b0;
        end
    end

    // Statistics counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else if (accept) begin
            if (br_cnt_q != '1) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (mispredict && mp_cnt_q != '1) begin
                mp_cnt_q <= mp_cnt_q + 32'd1;
            end
        end
    end

    assign bus.ready_out        = ready;
    assign bus.lookup_taken_out = lookup_taken;
    assign bus.valid_out        = valid_q;
    assign bus.taken_out        = taken_q;
    assign bus.br_pc_out        = br_pc_q;
    assign bus.no_br_pc_out     = no_br_pc_q;
    assign bus.mis_out          = mis_q;
    assign bus.mispredict_out   = mispredict_q;
    assign bus.br_cnt_out       = br_cnt_q;
    assign bus.mp_cnt_out       = mp_cnt_q;

endmodule

// File: tb/tb_br_pred_fu.sv
// Randomized and directed bench for br_pred_fu; two instances (EXT_C 0 and 1)
// share one stimulus stream and are checked against a behavioural model.
module tb_br_pred_fu;
    import cpu_structs_pkg::*;

    localparam int RSZ   = 32;
    localparam int PC_SZ = 32;
    localparam int DEPTH = 64;

    typedef struct {
        bit        taken;
        bit [31:0] br_pc;
        bit [31:0] no_br_pc;
        bit        mis;
        bit        mp;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    br_pred_fu_if #(.RSZ(RSZ), .PC_SZ(PC_SZ)) bus0 ();
    br_pred_fu_if #(.RSZ(RSZ), .PC_SZ(PC_SZ)) bus1 ();

    br_pred_fu #(.RSZ(RSZ), .PC_SZ(PC_SZ), .BHT_DEPTH(DEPTH), .EXT_C(0)) dut0 (
        .clk_in(clk), .reset_in(rst), .bus(bus0));
    br_pred_fu #(.RSZ(RSZ), .PC_SZ(PC_SZ), .BHT_DEPTH(DEPTH), .EXT_C(1)) dut1 (
        .clk_in(clk), .reset_in(rst), .bus(bus1));

    assign bus1.flush_in      = bus0.flush_in;
    assign bus1.valid_in      = bus0.valid_in;
    assign bus1.op_in         = bus0.op_in;
    assign bus1.sel_x_in      = bus0.sel_x_in;
    assign bus1.sel_y_in      = bus0.sel_y_in;
    assign bus1.rs1_in        = bus0.rs1_in;
    assign bus1.rs2_in        = bus0.rs2_in;
    assign bus1.imm_in        = bus0.imm_in;
    assign bus1.pc_in         = bus0.pc_in;
    assign bus1.funct3_in     = bus0.funct3_in;
    assign bus1.ci_in         = bus0.ci_in;
    assign bus1.mepc_in       = bus0.mepc_in;
    assign bus1.pred_taken_in = bus0.pred_taken_in;
    assign bus1.pred_pc_in    = bus0.pred_pc_in;
    assign bus1.lookup_pc_in  = bus0.lookup_pc_in;
    assign bus1.ready_in      = bus0.ready_in;

    // Reference model state
    bit      m_valid;
    res_t    m_res [2];
    longint  m_br_cnt;
    longint  m_mp_cnt;
    int      bht [2][DEPTH];
    int      n_checks;
    int      n_pass;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit [31:0] operand(BR_SEL_TYPE sel, bit [31:0] rs1,
                                          bit [31:0] imm, bit [31:0] pc);
        case (sel)
            BS_RS1:  return rs1;
            BS_IMM:  return imm;
            BS_PC:   return pc;
            default: return 32'd0;
        endcase
    endfunction

    // Resolve one branch straight from the architectural rules.
    function automatic res_t resolve(int ext, BR_OP_TYPE op, BR_SEL_TYPE sx,
                                     BR_SEL_TYPE sy, bit [31:0] rs1, bit [31:0] rs2,
                                     bit [31:0] imm, bit [31:0] pc, bit [2:0] f3,
                                     bit ci, bit [31:0] mepc, bit pt, bit [31:0] ppc);
        res_t r;
        longint unsigned sum;
        bit [31:0] sum32;
        bit c;
        sum   = longint'(operand(sx, rs1, imm, pc)) + longint'(operand(sy, rs1, imm, pc));
        sum32 = sum[31:0];
        r.no_br_pc = ci ? pc + 32'd2 : pc + 32'd4;
        case (f3)
            3'd0:    c = (rs1 == rs2);
            3'd1:    c = (rs1 != rs2);
            3'd4:    c = ($signed(rs1) < $signed(rs2));
            3'd5:    c = !($signed(rs1) < $signed(rs2));
            3'd6:    c = (rs1 < rs2);
            3'd7:    c = !(rs1 < rs2);
            default: c = 1'b0;
        endcase
        r.taken = 1'b1;
        case (op)
            B_ADD: begin
                r.taken = c;
                r.br_pc = c ? sum32 : r.no_br_pc;
            end
            B_JAL:   r.br_pc = sum32;
            B_JALR:  r.br_pc = sum32 & ~32'd1;
            default: r.br_pc = mepc;
        endcase
        r.mis = (ext != 0) ? 1'b0 : (r.br_pc % 4 != 0);
        r.mp  = (r.taken != pt) || (r.taken && r.br_pc != ppc);
        return r;
    endfunction

    function automatic int bidx(int ext, bit [31:0] pc);
        return (ext != 0) ? int'((pc / 2) % DEPTH) : int'((pc / 4) % DEPTH);
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_br_cnt = 0;
        m_mp_cnt = 0;
        for (int e = 0; e < 2; e++) begin
            m_res[e] = '{default: 0};
            for (int i = 0; i < DEPTH; i++) bht[e][i] = 1;
        end
    endtask

    task automatic set_instr(BR_OP_TYPE op, BR_SEL_TYPE sx, BR_SEL_TYPE sy,
                             bit [31:0] rs1, bit [31:0] rs2, bit [31:0] imm,
                             bit [31:0] pc, bit [2:0] f3, bit ci, bit pt,
                             bit [31:0] ppc);
        bus0.op_in = op;          bus0.sel_x_in = sx;       bus0.sel_y_in = sy;
        bus0.rs1_in = rs1;        bus0.rs2_in = rs2;        bus0.imm_in = imm;
        bus0.pc_in = pc;          bus0.funct3_in = f3;      bus0.ci_in = ci;
        bus0.pred_taken_in = pt;  bus0.pred_pc_in = ppc;
    endtask

    task automatic check_outputs();
        check("valid0", bus0.valid_out, m_valid);
        check("valid1", bus1.valid_out, m_valid);
        check("br_cnt0", bus0.br_cnt_out, m_br_cnt);
        check("mp_cnt0", bus0.mp_cnt_out, m_mp_cnt);
        check("br_cnt1", bus1.br_cnt_out, m_br_cnt);
        check("mp_cnt1", bus1.mp_cnt_out, m_mp_cnt);
        if (m_valid) begin
            check("taken0", bus0.taken_out, m_res[0].taken);
            check("br_pc0", bus0.br_pc_out, m_res[0].br_pc);
            check("no_br_pc0", bus0.no_br_pc_out, m_res[0].no_br_pc);
            check("mis0", bus0.mis_out, m_res[0].mis);
            check("mispredict0", bus0.mispredict_out, m_res[0].mp);
            check("taken1", bus1.taken_out, m_res[1].taken);
            check("br_pc1", bus1.br_pc_out, m_res[1].br_pc);
            check("no_br_pc1", bus1.no_br_pc_out, m_res[1].no_br_pc);
            check("mis1", bus1.mis_out, m_res[1].mis);
            check("mispredict1", bus1.mispredict_out, m_res[1].mp);
        end
    endtask

    // One clock: pre-edge checks of combinational outputs, edge, model update.
    task automatic tick();
        bit   acc;
        res_t r [2];
        #1;
        check("ready_out0", bus0.ready_out, !m_valid || bus0.ready_in);
        check("ready_out1", bus1.ready_out, !m_valid || bus0.ready_in);
        check("lookup0", bus0.lookup_taken_out, bht[0][bidx(0, bus0.lookup_pc_in)] >= 2);
        check("lookup1", bus1.lookup_taken_out, bht[1][bidx(1, bus0.lookup_pc_in)] >= 2);
        acc = bus0.valid_in && (!m_valid || bus0.ready_in) && !bus0.flush_in;
        for (int e = 0; e < 2; e++) begin
            r[e] = resolve(e, bus0.op_in, bus0.sel_x_in, bus0.sel_y_in, bus0.rs1_in,
                           bus0.rs2_in, bus0.imm_in, bus0.pc_in, bus0.funct3_in,
                           bus0.ci_in, bus0.mepc_in, bus0.pred_taken_in, bus0.pred_pc_in);
        end
        @(posedge clk);
        #1;
        if (bus0.flush_in) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_res   = r;
            m_br_cnt++;
            if (r[0].mp) m_mp_cnt++;
            if (bus0.op_in == B_ADD) begin
                for (int e = 0; e < 2; e++) begin
                    int k = bidx(e, bus0.pc_in);
                    if (r[e].taken) bht[e][k] = (bht[e][k] == 3) ? 3 : bht[e][k] + 1;
                    else            bht[e][k] = (bht[e][k] == 0) ? 0 : bht[e][k] - 1;
                end
            end
        end else if (bus0.ready_in) begin
            m_valid = 1'b0;
        end
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t   saved;
        longint saved_br;
        longint saved_mp;

        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus0.flush_in = 1'b0;
        bus0.valid_in = 1'b0;
        bus0.ready_in = 1'b1;
        bus0.mepc_in  = 32'h8000_0000;
        bus0.lookup_pc_in = 32'h0;
        set_instr(B_ADD, BS_PC, BS_IMM, 0, 0, 0, 0, 3'd0, 1'b0, 1'b0, 0);
        model_reset();

        // Reset state
        #2;
        check("rst_valid0", bus0.valid_out, 0);
        check("rst_valid1", bus1.valid_out, 0);
        check("rst_taken", bus0.taken_out, 0);
        check("rst_br_pc", bus0.br_pc_out, 0);
        check("rst_no_br_pc", bus0.no_br_pc_out, 0);
        check("rst_mis", bus0.mis_out, 0);
        check("rst_mispredict", bus0.mispredict_out, 0);
        check("rst_br_cnt", bus0.br_cnt_out, 0);
        check("rst_mp_cnt", bus0.mp_cnt_out, 0);
        check("rst_ready", bus0.ready_out, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // beq taken, predicted not taken
        set_instr(B_ADD, BS_PC, BS_IMM, 5, 5, 32'h20, 32'h100, 3'd0, 1'b0, 1'b0, 32'h104);
        bus0.valid_in = 1'b1;
        tick();
        bus0.valid_in = 1'b0;
        check("beq_valid", bus0.valid_out, 1);
        check("beq_taken", bus0.taken_out, 1);
        check("beq_br_pc", bus0.br_pc_out, 32'h120);
        check("beq_mispredict", bus0.mispredict_out, 1);
        check("beq_mp_cnt", bus0.mp_cnt_out, 1);

        // bltu not taken on a compressed instruction
        set_instr(B_ADD, BS_PC, BS_IMM, 32'hFFFF_FFFF, 1, 32'h10, 32'h200, 3'd6, 1'b1,
                  1'b0, 32'h202);
        bus0.valid_in = 1'b1;
        tick();
        bus0.valid_in = 1'b0;
        check("bltu_taken", bus0.taken_out, 0);
        check("bltu_br_pc", bus0.br_pc_out, 32'h202);
        check("bltu_no_br_pc", bus0.no_br_pc_out, 32'h202);
        check("bltu_mispredict", bus0.mispredict_out, 0);

        // BHT training at 0x40: lookups 0,1,1, saturation, then decay
        bus0.lookup_pc_in = 32'h40;
        bus0.valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(B_ADD, BS_PC, BS_IMM, 7, 7, 32'h8, 32'h40, 3'd0, 1'b0, 1'b1, 32'h48);
            #1;
            check("bht_seq", bus0.lookup_taken_out, (i == 0) ? 0 : 1);
            tick();
        end
        #1;
        check("bht_after3", bus0.lookup_taken_out, 1);
        for (int i = 0; i < 2; i++) begin
            set_instr(B_ADD, BS_PC, BS_IMM, 7, 8, 32'h8, 32'h40, 3'd0, 1'b0, 1'b0, 32'h44);
            tick();
        end
        #1;
        check("bht_sat_decay0", bus0.lookup_taken_out, 0);
        check("bht_sat_decay1", bus1.lookup_taken_out, 0);

        // jalr: bit 0 cleared, misalignment depends on EXT_C
        set_instr(B_JALR, BS_RS1, BS_IMM, 32'h1001, 0, 2, 32'h300, 3'd0, 1'b0, 1'b1, 32'h1002);
        tick();
        bus0.valid_in = 1'b0;
        check("jalr_br_pc0", bus0.br_pc_out, 32'h1002);
        check("jalr_br_pc1", bus1.br_pc_out, 32'h1002);
        check("jalr_mis0", bus0.mis_out, 1);
        check("jalr_mis1", bus1.mis_out, 0);

        // Backpressure: outputs hold while ready_in is low, then flush
        set_instr(B_JAL, BS_PC, BS_IMM, 0, 0, 32'h40, 32'h500, 3'd0, 1'b0, 1'b1, 32'h540);
        bus0.valid_in = 1'b1;
        tick();
        saved = m_res[0];
        saved_br = m_br_cnt;
        saved_mp = m_mp_cnt;
        bus0.ready_in = 1'b0;
        set_instr(B_MRET, BS_RS1, BS_RS1, 1, 2, 3, 32'h600, 3'd0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_ready", bus0.ready_out, 0);
            check("hold_valid", bus0.valid_out, 1);
            check("hold_br_pc", bus0.br_pc_out, saved.br_pc);
            check("hold_taken", bus0.taken_out, saved.taken);
        end
        bus0.flush_in = 1'b1;
        tick();
        check("flush_valid", bus0.valid_out, 0);
        check("flush_br_cnt", bus0.br_cnt_out, saved_br);
        check("flush_mp_cnt", bus0.mp_cnt_out, saved_mp);
        bus0.flush_in = 1'b0;
        bus0.valid_in = 1'b0;
        bus0.ready_in = 1'b1;
        tick();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bus0.valid_in = ($urandom_range(0, 3) != 0);
            bus0.ready_in = ($urandom_range(0, 3) != 0);
            bus0.flush_in = ($urandom_range(0, 15) == 0);
            bus0.op_in    = BR_OP_TYPE'($urandom_range(0, 3));
            bus0.sel_x_in = BR_SEL_TYPE'($urandom_range(0, 3));
            bus0.sel_y_in = BR_SEL_TYPE'($urandom_range(0, 3));
            bus0.rs1_in   = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 7);
            bus0.rs2_in   = ($urandom_range(0, 2) == 0) ? bus0.rs1_in : $urandom_range(0, 7);
            bus0.imm_in   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 255);
            bus0.pc_in    = ($urandom_range(0, 7) == 0) ? ($urandom | 32'hFFFF_FFF0)
                                                        : $urandom_range(0, 511) * 2;
            bus0.funct3_in = 3'($urandom_range(0, 7));
            bus0.ci_in     = 1'($urandom_range(0, 1));
            bus0.mepc_in   = $urandom;
            bus0.pred_taken_in = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       bus0.pred_pc_in = bus0.pc_in + 32'd4;
                1:       bus0.pred_pc_in = bus0.pc_in + bus0.imm_in;
                2:       bus0.pred_pc_in = bus0.pc_in + 32'd2;
                default: bus0.pred_pc_in = $urandom;
            endcase
            bus0.lookup_pc_in = $urandom_range(0, 511) * 2;
            tick();
        end

        // Reset in the middle of traffic
        bus0.flush_in = 1'b0;
        bus0.ready_in = 1'b0;
        bus0.valid_in = 1'b1;
        set_instr(B_JAL, BS_PC, BS_IMM, 0, 0, 32'h10, 32'h700, 3'd0, 1'b0, 1'b0, 0);
        tick();
        check("pre_rst_valid", bus0.valid_out, 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_valid0", bus0.valid_out, 0);
        check("async_rst_valid1", bus1.valid_out, 0);
        check("async_rst_br_cnt", bus0.br_cnt_out, 0);
        check("async_rst_mp_cnt", bus0.mp_cnt_out, 0);
        bus0.ready_in = 1'b1;
        set_instr(B_ADD, BS_PC, BS_IMM, 1, 1, 4, 32'h40, 3'd0, 1'b0, 1'b1, 32'h44);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_rst_valid", bus0.valid_out, 0);
        check("in_rst_br_cnt", bus0.br_cnt_out, 0);
        rst = 1'b0;
        bus0.valid_in = 1'b0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            bus0.lookup_pc_in = i * 2;
            #1;
            check("post_rst_lookup0", bus0.lookup_taken_out, 0);
            check("post_rst_lookup1", bus1.lookup_taken_out, 0);
        end

        // One taken branch from the weakly-not-taken state flips the prediction
        @(negedge clk);
        bus0.lookup_pc_in = 32'h40;
        bus0.valid_in = 1'b1;
        tick();
        bus0.valid_in = 1'b0;
        #1;
        check("post_rst_train0", bus0.lookup_taken_out, 1);
        check("post_rst_train1", bus1.lookup_taken_out, 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/br_pred_fu.md
BR_PRED_FU -- requirements
Module: br_pred_fu

Interface
REQ-001 SHALL provide parameter RSZ, default 32, register data width.
REQ-002 SHALL provide parameter PC_SZ, default 32, program counter width.
REQ-003 SHALL provide parameter BHT_DEPTH, default 64, branch history table entries; must be a power of 2 and at least 4.
REQ-004 SHALL provide parameter EXT_C, default 0; 1 means compressed instructions are supported.
REQ-005 SHALL have ports, one per line:
- clk_in  in  1  the single clock.
- reset_in  in  1  asynchronous, active-high reset.
- flush_in  in  1  discards the in-flight and offered instruction.
- valid_in / ready_out  in / out  1 / 1  input handshake from EXE.
- op_in  in  BR_OP_TYPE  B_ADD, B_JAL, B_JALR, B_MRET.
- sel_x_in, sel_y_in  in  BR_SEL_TYPE  operand mux selects: BS_RS1, BS_IMM, BS_PC.
- rs1_in, rs2_in, imm_in  in  RSZ  operands.
- pc_in  in  PC_SZ  PC of the branch.
- funct3_in  in  3  branch condition.
- ci_in  in  1  16-bit instruction.
- mepc_in  in  PC_SZ  mret target.
- pred_taken_in, pred_pc_in  in  1, PC_SZ  prediction made by fetch for this instruction.
- lookup_pc_in  in  PC_SZ  fetch-side BHT query.
- lookup_taken_out  out  1  predicted direction for lookup_pc_in.
- valid_out / ready_in  out / in  1 / 1  output handshake.
- taken_out, br_pc_out, no_br_pc_out  out  1, PC_SZ, PC_SZ  resolved result.
- mis_out  out  1  target is misaligned.
- mispredict_out  out  1  fetch must redirect to br_pc_out.
- br_cnt_out, mp_cnt_out  out  32, 32  statistics counters.

Function
REQ-006 SHALL compute X and Y from the selects (undefined select gives 0), and addxy = X + Y truncated to PC_SZ.
REQ-007 SHALL set no_br_pc = pc + 2 when ci_in is 1, else pc + 4, with modulo-2^PC_SZ wrap.
REQ-008 B_ADD direction SHALL follow funct3: 0 eq, 1 ne, 4 signed lt, 5 signed ge, 6 unsigned lt, 7 unsigned ge; funct3 values 2 and 3 give not taken.
REQ-009 Target selection SHALL be:
- B_ADD: taken ? addxy : no_br_pc.
- B_JAL: addxy, always taken.
- B_JALR: addxy with bit 0 cleared, always taken.
- B_MRET: mepc_in, always taken.
REQ-010 mis SHALL be 0 when EXT_C is 1, else br_pc[1:0] != 0.
REQ-011 mispredict SHALL be (taken != pred_taken_in) | (taken & br_pc != pred_pc_in).
REQ-012 Result handling:
- Results SHALL be registered in one output stage; latency is 1 cycle from the accepting edge to valid_out.
- ready_out SHALL equal !valid_out | ready_in.
- A transfer occurs on valid & ready.
- Output registers SHALL hold stable while valid_out & !ready_in.
REQ-013 Input is accepted only when valid_in & ready_out & !flush_in; on flush_in, valid_out SHALL clear next cycle and the offered input is dropped without side effects.
REQ-014 BHT behaviour:
- The BHT is BHT_DEPTH 2-bit saturating counters, indexed by pc[log2(BHT_DEPTH)+1:2] when EXT_C is 0, or pc[log2(BHT_DEPTH):1] when EXT_C is 1.
- lookup_taken_out = counter[msb] of the lookup index, combinational.
REQ-015 BHT update:
- An accepted B_ADD SHALL increment (saturate at 3) if taken, else decrement (saturate at 0).
- Other ops do not update.
REQ-016 A lookup and update to the same index in the same cycle SHALL return the pre-update value.
REQ-017 Statistics:
- br_cnt SHALL increment on every accepted instruction.
- mp_cnt SHALL increment on accepted instructions with mispredict = 1.
- Both saturate at 0xFFFFFFFF.

Reset
REQ-018 On reset_in (asynchronous), the following SHALL apply:
- valid_out = 0.
- All result outputs = 0.
- br_cnt = mp_cnt = 0.
- All BHT counters = 2'b01 (weakly not taken).
REQ-019 Reset asserted mid-transfer SHALL drop the in-flight result; no BHT or counter update occurs during reset.

Structure
REQ-020 BR_OP_TYPE and BR_SEL_TYPE SHALL live in cpu_structs_pkg; the BHT_DEPTH default SHALL live in cpu_params_pkg.
REQ-021 The counter table SHALL be a sub-module br_bht with one read port, one update port and the async reset.

Verification
REQ-022 beq with rs1 = rs2 = 5, pc 0x100, imm 0x20, pred_taken 0 -> one cycle later: taken 1, br_pc 0x120, mispredict 1, mp_cnt 1.
REQ-023 bltu with rs1 = 0xFFFFFFFF, rs2 = 1, ci 1, pc 0x200 -> taken 0, br_pc = no_br_pc = 0x202; with a prediction of not taken and pred_pc 0x202 -> mispredict 0.
REQ-024 Three taken branches at pc 0x40, then a lookup of 0x40 -> lookup_taken sequence 0, 1, 1, and the counter saturates at 3; a lookup in the same cycle as the first update reads 0.
REQ-025 jalr with rs1 = 0x1001, imm 2, EXT_C 0 -> br_pc 0x1002, mis 1; with EXT_C 1 -> mis 0.
REQ-026 Hold ready_in = 0 for 3 cycles with valid_out = 1 -> outputs stable and ready_out = 0; then flush_in -> valid_out = 0 and counters unchanged.
REQ-027 Assert reset_in mid-stream -> valid_out drops immediately (asynchronously), and the BHT reads 01 for all indices afterwards.
